icache_dataram_rd_ctrl: RTL and testbench
=========================================

// Module: icache_dataram_rd_ctrl
// PURPOSE
// Downstream of the icache tag stage. Accepts hit reads (index/way/txnid) and
// MSHR linefill writes, and owns the 2-way icache data RAM (1-cycle sync read).
// Read data goes to the fetch side through a credit-guarded response FIFO with
// valid/ready. Raises dataram_rd_rdy, which the tag stage folds into its rd_vld.
// PARAMETERS
// INDEX_WIDTH      7    set index width (2**INDEX_WIDTH sets)
// WAY_NUM          2    ways; RAM address = {way, index}
// LINE_WIDTH       256  cache line data width, bits
// TXNID_WIDTH      5    transaction id width
// RESP_DEPTH       4    response FIFO entries (power of 2, >=2)
// PORTS
// clk              in   1            clock
// rst_n            in   1            async active-low reset
// rd_vld           in   1            hit read request; rdy-qualified upstream
// rd_index         in   INDEX_WIDTH  read set index
// rd_way           in   1            read way (0/1)
// rd_txnid         in   TXNID_WIDTH  read txn id
// dataram_rd_rdy   out  1            read may be issued this cycle
// lf_wr_vld        in   1            linefill write request
// lf_wr_rdy        out  1            linefill write accepted
// lf_wr_index      in   INDEX_WIDTH  linefill set index
// lf_wr_way        in   1            linefill dest way
// lf_wr_data       in   LINE_WIDTH   linefill line data
// resp_vld         out  1            response valid to fetch
// resp_rdy         in   1            fetch accepts response
// resp_txnid       out  TXNID_WIDTH  response txn id
// resp_data        out  LINE_WIDTH   response line data
// busy             out  1            read in flight or FIFO non-empty
// BEHAVIOUR
// - Reset: clk and rst_n as above. dataram_rd_rdy=1, lf_wr_rdy=1, resp_vld=0,
//   busy=0, FIFO empty, in-flight flag=0. RAM contents are not reset.
// - Arbitration: linefill write has priority. lf_wr_rdy=1 always.
//   dataram_rd_rdy = !lf_wr_vld && (fifo_count + inflight < RESP_DEPTH).
//   dataram_rd_rdy must not depend combinationally on rd_vld.
// - rd_vld asserted with dataram_rd_rdy=0 is a protocol error. Assert it in
//   simulation. Never issue it to the RAM.
// - Read: cycle T accept -> RAM en, addr={rd_way,rd_index}. Set inflight and
//   capture txnid. T+1: RAM data + txnid pushed into FIFO, inflight cleared.
//   Earliest resp_vld is T+1 (FIFO has show-ahead output; bypass allowed when
//   the FIFO is empty).
// - Back-to-back reads: allowed every cycle while credits remain. With
//   RESP_DEPTH=4 and resp_rdy=0, exactly 4 reads are accepted, then rdy=0.
// - Write: lf_wr_vld -> RAM write to {lf_wr_way,lf_wr_index} in the same
//   cycle. A same-address read in the next cycle returns the new data.
// - FIFO: push on inflight; pop on resp_vld&&resp_rdy. Simultaneous push and
//   pop keeps the count. Pointers wrap modulo RESP_DEPTH. Credit counting
//   guarantees no overflow: push while full = assertion.
// - resp_txnid and resp_data hold stable while resp_vld && !resp_rdy.
// - busy = inflight | (fifo_count != 0).
// - Async reset mid-operation: drops the in-flight read and all FIFO entries.
//   No response appears after reset release.
// TESTING
// - Reset check: after rst_n release, dataram_rd_rdy=1, resp_vld=0, busy=0.
// - Write then read: write way1 idx 0x05 data 0xA5..A5. Next cycle read
//   (0x05,1,txn 3). Expect resp_vld at +1 with txnid 3 and data 0xA5..A5.
// - Backpressure: resp_rdy=0, issue reads every cycle. Exactly 4 accepted,
//   then dataram_rd_rdy=0. Raise resp_rdy: 4 responses in issue order
//   (txn 0,1,2,3); rdy returns the cycle after the first pop.
// - Write priority: lf_wr_vld=1 for 3 cycles. dataram_rd_rdy=0 in those
//   cycles. The write lands, and the read issued afterwards sees the new data.
// - Streaming: resp_rdy=1, 50 random reads to pre-filled lines. Responses in
//   order, data matches the scoreboard, no bubble beyond the 1-cycle latency.
// - Reset mid-flight: 3 responses queued with resp_rdy=0, assert rst_n low.
//   Expect resp_vld=0 and busy=0 immediately, and no stale response later.

Source files
------------

// File: rtl/icache_dataram_rd_ctrl.sv
// Icache data RAM read controller: owns the 2-way data RAM, arbitrates linefill
// writes over hit reads, and returns read data through a credit-guarded response FIFO.
module icache_dataram_rd_ctrl #(
  parameter int unsigned INDEX_WIDTH = 7,
  parameter int unsigned WAY_NUM     = 2,
  parameter int unsigned LINE_WIDTH  = 256,
  parameter int unsigned TXNID_WIDTH = 5,
  parameter int unsigned RESP_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rd_vld,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  input  logic                   rd_way,
  input  logic [TXNID_WIDTH-1:0] rd_txnid,
  output logic                   dataram_rd_rdy,
  input  logic                   lf_wr_vld,
  output logic                   lf_wr_rdy,
  input  logic [INDEX_WIDTH-1:0] lf_wr_index,
  input  logic                   lf_wr_way,
  input  logic [LINE_WIDTH-1:0]  lf_wr_data,
  output logic                   resp_vld,
  input  logic                   resp_rdy,
  output logic [TXNID_WIDTH-1:0] resp_txnid,
  output logic [LINE_WIDTH-1:0]  resp_data,
  output logic                   busy
);

  localparam int unsigned ADDR_W    = INDEX_WIDTH + 1;
  localparam int unsigned RAM_DEPTH = WAY_NUM * (2 ** INDEX_WIDTH);
  localparam int unsigned PTR_W     = $clog2(RESP_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  logic [LINE_WIDTH-1:0]  ram_q [RAM_DEPTH];
  logic [LINE_WIDTH-1:0]  ram_rdata_q;
  logic [LINE_WIDTH-1:0]  fifo_data_q [RESP_DEPTH];
  logic [TXNID_WIDTH-1:0] fifo_txnid_q [RESP_DEPTH];

  logic                   inflight_q, inflight_d;
  logic [TXNID_WIDTH-1:0] inflight_txnid_q, inflight_txnid_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic              fifo_empty;
  logic              rd_fire;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  credits_used;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  assign lf_wr_rdy = 1'b1;
  assign rd_addr   = {rd_way, rd_index};
  assign wr_addr   = {lf_wr_way, lf_wr_index};

  always_comb begin
    fifo_empty     = (count_q == '0);
    credits_used   = count_q + CNT_W'(inflight_q);
    dataram_rd_rdy = !lf_wr_vld && (credits_used < CNT_W'(RESP_DEPTH));
    rd_fire        = rd_vld && dataram_rd_rdy;

    // With an empty FIFO the RAM output is presented directly; it is only
    // queued when fetch does not take it in the same cycle.
    resp_vld   = inflight_q || !fifo_empty;
    resp_txnid = fifo_empty ? inflight_txnid_q : fifo_txnid_q[rd_ptr_q];
    resp_data  = fifo_empty ? ram_rdata_q      : fifo_data_q[rd_ptr_q];
    busy       = inflight_q || !fifo_empty;

    pop  = !fifo_empty && resp_rdy;
    push = inflight_q && !(fifo_empty && resp_rdy);

    inflight_d       = rd_fire;
    inflight_txnid_d = rd_fire ? rd_txnid : inflight_txnid_q;
    wr_ptr_d         = wr_ptr_q + PTR_W'(push);
    rd_ptr_d         = rd_ptr_q + PTR_W'(pop);
    count_d          = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (lf_wr_vld) begin
      ram_q[wr_addr] <= lf_wr_data;
    end
    if (rd_fire) begin
      ram_rdata_q <= ram_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q]  <= ram_rdata_q;
      fifo_txnid_q[wr_ptr_q] <= inflight_txnid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q       <= 1'b0;
      inflight_txnid_q <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      inflight_q       <= inflight_d;
      inflight_txnid_q <= inflight_txnid_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

  rd_protocol_chk: assert property (@(posedge clk) disable iff (!rst_n)
    rd_vld |-> dataram_rd_rdy);

  fifo_overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (count_q != CNT_W'(RESP_DEPTH)));

endmodule

// File: tb/tb_icache_dataram_rd_ctrl.sv
// Bench for icache_dataram_rd_ctrl: random traffic scored against a line-memory
// model and an ordered queue of outstanding reads.
module tb_icache_dataram_rd_ctrl;

  localparam int unsigned IW    = 7;
  localparam int unsigned LW    = 256;
  localparam int unsigned TW    = 5;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_vld;
  logic [IW-1:0] rd_index;
  logic          rd_way;
  logic [TW-1:0] rd_txnid;
  logic          dataram_rd_rdy;
  logic          lf_wr_vld;
  logic          lf_wr_rdy;
  logic [IW-1:0] lf_wr_index;
  logic          lf_wr_way;
  logic [LW-1:0] lf_wr_data;
  logic          resp_vld;
  logic          resp_rdy;
  logic [TW-1:0] resp_txnid;
  logic [LW-1:0] resp_data;
  logic          busy;

  always #5 clk = ~clk;

  icache_dataram_rd_ctrl #(
    .INDEX_WIDTH(IW), .WAY_NUM(2), .LINE_WIDTH(LW), .TXNID_WIDTH(TW), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_vld(rd_vld), .rd_index(rd_index), .rd_way(rd_way), .rd_txnid(rd_txnid),
    .dataram_rd_rdy(dataram_rd_rdy),
    .lf_wr_vld(lf_wr_vld), .lf_wr_rdy(lf_wr_rdy), .lf_wr_index(lf_wr_index),
    .lf_wr_way(lf_wr_way), .lf_wr_data(lf_wr_data),
    .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_txnid(resp_txnid),
    .resp_data(resp_data), .busy(busy)
  );

  typedef struct {
    logic [TW-1:0] txn;
    logic [LW-1:0] data;
    int unsigned   cyc;
  } resp_t;

  resp_t         expq[$];
  logic [LW-1:0] mdl [256];
  int unsigned   cyc;
  logic          exp_vld, exp_rdy, exp_busy;
  logic [TW-1:0] exp_txn;
  logic [LW-1:0] exp_data;
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Drives one cycle, then at the falling edge computes what the DUT must show
  // this cycle and advances the model past the coming rising edge.
  task automatic cycle(input logic lf, input logic [IW-1:0] lidx, input logic lway,
                       input logic [LW-1:0] ldata, input logic rd, input logic [IW-1:0] ridx,
                       input logic rway, input logic [TW-1:0] rtxn, input logic rr);
    @(posedge clk);
    #1;
    lf_wr_vld = lf; lf_wr_index = lidx; lf_wr_way = lway; lf_wr_data = ldata;
    rd_vld = rd; rd_index = ridx; rd_way = rway; rd_txnid = rtxn; resp_rdy = rr;
    @(negedge clk);
    exp_rdy  = !lf && (expq.size() < DEPTH);
    exp_busy = (expq.size() != 0);
    exp_vld  = (expq.size() != 0) && (expq[0].cyc < cyc);
    if (exp_vld) begin
      exp_txn  = expq[0].txn;
      exp_data = expq[0].data;
    end
    if (exp_vld && rr) void'(expq.pop_front());
    if (rd) expq.push_back('{rtxn, mdl[{rway, ridx}], cyc});
    if (lf) mdl[{lway, lidx}] = ldata;
    cyc++;
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, '0, rr);
  endtask

  task automatic rd_req(input logic [IW-1:0] idx, input logic way, input logic [TW-1:0] txn,
                        input logic rr);
    cycle(1'b0, '0, 1'b0, '0, 1'b1, idx, way, txn, rr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_vld = 1'b0; rd_index = '0; rd_way = 1'b0; rd_txnid = '0;
    lf_wr_vld = 1'b0; lf_wr_index = '0; lf_wr_way = 1'b0; lf_wr_data = '0; resp_rdy = 1'b0;
    expq.delete();
    cyc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (dataram_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rd_rdy got %b exp 1", dataram_rd_rdy); end
    n_checks++; if (lf_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_lf_wr_rdy got %b exp 1", lf_wr_rdy); end
    n_checks++; if (resp_vld !== 1'b0) begin n_fail++; $display("FAIL reset_resp_vld got %b exp 0", resp_vld); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic prefill();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] a8;
      a8 = 8'(a);
      cycle(1'b1, a8[6:0], a8[7], rand_line(), 1'b0, '0, 1'b0, '0, 1'b0);
      n_checks++; if (dataram_rd_rdy !== 1'b0) begin n_fail++; $display("FAIL prefill_rd_rdy addr %0d got %b exp 0", a, dataram_rd_rdy); end
    end
  endtask

  task automatic test_write_then_read();
    logic [LW-1:0] a5;
    a5 = {32{8'hA5}};
    cycle(1'b1, 7'h05, 1'b1, a5, 1'b0, '0, 1'b0, '0, 1'b1);
    n_checks++; if (dataram_rd_rdy !== 1'b0) begin n_fail++; $display("FAIL wtr_rdy_on_write got %b exp 0", dataram_rd_rdy); end
    rd_req(7'h05, 1'b1, 5'd3, 1'b1);
    n_checks++; if (dataram_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL wtr_rdy_on_read got %b exp 1", dataram_rd_rdy); end
    n_checks++; if (resp_vld !== 1'b0) begin n_fail++; $display("FAIL wtr_vld_at_issue got %b exp 0", resp_vld); end
    idle(1'b1);
    n_checks++; if (resp_vld !== 1'b1) begin n_fail++; $display("FAIL wtr_vld_plus1 got %b exp 1", resp_vld); end
    n_checks++; if (resp_txnid !== 5'd3) begin n_fail++; $display("FAIL wtr_txnid got %0d exp 3", resp_txnid); end
    n_checks++; if (resp_data !== a5) begin n_fail++; $display("FAIL wtr_data got %h exp %h", resp_data, a5); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wtr_busy got %b exp 1", busy); end
    idle(1'b1);
    n_checks++; if (resp_vld !== 1'b0) begin n_fail++; $display("FAIL wtr_vld_after got %b exp 0", resp_vld); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wtr_busy_after got %b exp 0", busy); end
  endtask

  task automatic test_backpressure();
    int unsigned issued;
    issued = 0;
    for (int i = 0; i < 6; i++) begin
      logic rd;
      rd = (expq.size() < DEPTH);
      cycle(1'b0, '0, 1'b0, '0, rd, IW'($urandom()), 1'($urandom()), TW'(issued), 1'b0);
      if (rd) issued++;
      n_checks++; if (dataram_rd_rdy !== (i < 4)) begin n_fail++; $display("FAIL bp_rdy cyc %0d got %b exp %b", i, dataram_rd_rdy, (i < 4)); end
      n_checks++; if (resp_vld !== exp_vld) begin n_fail++; $display("FAIL bp_vld cyc %0d got %b exp %b", i, resp_vld, exp_vld); end
      if (exp_vld) begin
        n_checks++; if (resp_txnid !== 5'd0) begin n_fail++; $display("FAIL bp_hold_txnid cyc %0d got %0d exp 0", i, resp_txnid); end
        n_checks++; if (resp_data !== exp_data) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got %h exp %h", i, resp_data, exp_data); end
      end
    end
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      n_checks++; if (dataram_rd_rdy !== (i > 0)) begin n_fail++; $display("FAIL drain_rdy cyc %0d got %b exp %b", i, dataram_rd_rdy, (i > 0)); end
      n_checks++; if (resp_vld !== (i < 4)) begin n_fail++; $display("FAIL drain_vld cyc %0d got %b exp %b", i, resp_vld, (i < 4)); end
      if (i < 4) begin
        n_checks++; if (resp_txnid !== TW'(i)) begin n_fail++; $display("FAIL drain_txnid cyc %0d got %0d exp %0d", i, resp_txnid, i); end
        n_checks++; if (resp_data !== exp_data) begin n_fail++; $display("FAIL drain_data cyc %0d got %h exp %h", i, resp_data, exp_data); end
      end
    end
  endtask

  task automatic test_write_priority();
    logic [IW-1:0] idx [3];
    logic          way [3];
    for (int i = 0; i < 3; i++) begin
      idx[i] = IW'($urandom());
      way[i] = 1'($urandom());
      cycle(1'b1, idx[i], way[i], rand_line(), 1'b0, '0, 1'b0, '0, 1'b1);
      n_checks++; if (dataram_rd_rdy !== 1'b0) begin n_fail++; $display("FAIL prio_rdy cyc %0d got %b exp 0", i, dataram_rd_rdy); end
    end
    for (int i = 0; i < 5; i++) begin
      if (i < 3) rd_req(idx[i], way[i], TW'(20 + i), 1'b1);
      else idle(1'b1);
      n_checks++; if (resp_vld !== exp_vld) begin n_fail++; $display("FAIL prio_vld cyc %0d got %b exp %b", i, resp_vld, exp_vld); end
      if (exp_vld) begin
        n_checks++; if (resp_txnid !== exp_txn) begin n_fail++; $display("FAIL prio_txnid cyc %0d got %0d exp %0d", i, resp_txnid, exp_txn); end
        n_checks++; if (resp_data !== exp_data) begin n_fail++; $display("FAIL prio_data cyc %0d got %h exp %h", i, resp_data, exp_data); end
      end
    end
  endtask

  task automatic test_streaming();
    int seen;
    seen = 0;
    for (int i = 0; i < 52; i++) begin
      if (i < 50) rd_req(IW'($urandom()), 1'($urandom()), TW'($urandom()), 1'b1);
      else idle(1'b1);
      n_checks++; if (dataram_rd_rdy !== exp_rdy) begin n_fail++; $display("FAIL stream_rdy cyc %0d got %b exp %b", i, dataram_rd_rdy, exp_rdy); end
      n_checks++; if (resp_vld !== exp_vld) begin n_fail++; $display("FAIL stream_vld cyc %0d got %b exp %b", i, resp_vld, exp_vld); end
      if (exp_vld) begin
        seen++;
        n_checks++; if (resp_txnid !== exp_txn) begin n_fail++; $display("FAIL stream_txnid cyc %0d got %0d exp %0d", i, resp_txnid, exp_txn); end
        n_checks++; if (resp_data !== exp_data) begin n_fail++; $display("FAIL stream_data cyc %0d got %h exp %h", i, resp_data, exp_data); end
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stream_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) rd_req(IW'($urandom()), 1'($urandom()), TW'(i + 8), 1'b0);
    idle(1'b0);
    n_checks++; if (resp_vld !== 1'b1) begin n_fail++; $display("FAIL mid_vld_before got %b exp 1", resp_vld); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (resp_vld !== 1'b0) begin n_fail++; $display("FAIL mid_vld_in_reset got %b exp 0", resp_vld); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy_in_reset got %b exp 0", busy); end
    expq.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      n_checks++; if (resp_vld !== 1'b0) begin n_fail++; $display("FAIL mid_stale_vld cyc %0d got %b exp 0", i, resp_vld); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy cyc %0d got %b exp 0", i, busy); end
      n_checks++; if (dataram_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rdy cyc %0d got %b exp 1", i, dataram_rd_rdy); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    prefill();
    test_write_then_read();
    test_backpressure();
    test_write_priority();
    test_streaming();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
